// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit adder, one nibble per clock, LSB nibble first; result valid NIB edges after accept.
// Start/result channels are valid/ready; no new operands are taken until the result is consumed. Optional subtract: SUB_EN.

module full_adder_4b (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  input  logic             op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [3:0]       fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_shift;
  logic             sub;

`ifdef SUB_EN
  assign sub = op;
`else
  // Addition only; op stays on the pinout but is masked off.
  assign sub = op & 1'b0;
`endif

  full_adder_4b u_fa (
    .a_i    (a_q[3:0]),
    .b_i    (b_q[3:0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  generate
    if (WIDTH == 4) begin : g_one_nib
      assign res_shift = fa_sum;
    end else begin : g_multi_nib
      assign res_shift = {fa_sum, res_q[WIDTH-1:4]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a_in;
          b_d     = sub ? ~b_in : b_in;
          carry_d = sub ? 1'b1 : cin_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        res_d   = res_shift;
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Outputs only move here, so a partial result is never visible.
          sum_d   = res_shift;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign sum_out     = sum_q;
  assign cout_out    = cout_q;

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Sequencing controller that performs WIDTH-bit additions on one shared `full_adder_4b` instance, one nibble per clock, least-significant nibble first. Operands arrive on a valid/ready start channel. The result leaves on a valid/ready result channel. The block is the area-saving alternative to chaining WIDTH/4 adders: it trades latency for a single 4-bit datapath, and owns the carry register and operand/result shift registers around that datapath.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 4
- NIB (localparam), WIDTH/4, nibble passes per operation

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operands and cin_in presented
- start_ready  output  1  controller can accept operands
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- cin_in  input  1  carry-in for addition
- op  input  1  0 = add, 1 = subtract (see Configuration)
- res_valid  output  1  sum_out/cout_out hold a completed result
- res_ready  input  1  consumer accepts result
- sum_out  output  WIDTH  result
- cout_out  output  1  carry out of the top nibble
- busy  output  1  high in RUN or DONE

## Operation
- The FSM has three states: IDLE, RUN and DONE. The reset state is IDLE.
- IDLE: start_ready=1. Acceptance occurs when start_valid & start_ready. On acceptance the block does the following and then goes to RUN:
  - a_reg<=a_in
  - b_reg<=b_in (or ~b_in when subtracting)
  - carry<=cin_in (or 1 when subtracting)
  - cnt<=0
- RUN: the adder sees a_reg[3:0], b_reg[3:0] and carry. On each edge:
  - a_reg and b_reg shift right by 4
  - the adder sum is shifted into res_reg from the top: res_reg <= {sum4, res_reg[WIDTH-1:4]}
  - carry<=adder cout
  - cnt<=cnt+1
- RUN exit: on the edge where cnt==NIB-1, the FSM goes to DONE, and cout_out and sum_out are loaded from the final carry and the completed res_reg.
- DONE: res_valid=1. The FSM stays in DONE until res_ready, then returns to IDLE.
- start_ready is 0 in RUN and DONE. start_valid is ignored there and has no effect on state.
- sum_out and cout_out are updated only on the RUN→DONE transition. They stay stable through DONE and afterwards until the next completion.
- Counter width is clog2(NIB), minimum 1 bit. For WIDTH=4 (NIB=1), RUN lasts exactly one cycle.
- Arithmetic is modulo 2^WIDTH. The carry beyond the top nibble appears only on cout_out.
- Asynchronous reset at any time, including mid-RUN or in DONE:
  - the operation is aborted and the FSM returns to IDLE
  - all registers clear
  - no partial result is ever presented

## Timing
- Reset values: start_ready=1, res_valid=0, busy=0, sum_out=0, cout_out=0.
- Latency: operands are accepted at edge T. res_valid is high after edge T+NIB.
- Minimum spacing between accepted operations is NIB+2 cycles: 1 IDLE cycle + NIB RUN cycles + 1 DONE cycle when res_ready is already high.
- res_ready high in the first DONE cycle completes the handshake at that edge. start_ready rises in the following cycle.
- All outputs are registered or decoded directly from state. No combinational path exists from start_valid or res_ready to any output.

## Configuration
- Macro: SUB_EN.
- Defined: op=1 at acceptance selects subtraction a_in − b_in.
  - b is captured inverted and the initial carry is 1; cin_in is ignored.
  - cout_out=1 means no borrow.
  - op is sampled only at acceptance.
- Undefined: op is ignored and every operation is an addition with cin_in. The op port remains present so the pinout does not change.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 → sum_out=0x5555, cout_out=0. res_valid rises exactly 4 edges after the accept edge.
- a=0xFFFF, b=0x0001, cin=0 → sum_out=0x0000, cout_out=1. This checks carry propagation across all 4 nibble passes. a=0xFFFF, b=0x0000, cin=1 must give the same result.
- Hold res_ready=0 for 3 cycles in DONE while pulsing start_valid with new operands:
  - sum_out and res_valid stay stable and start_ready stays 0
  - the new operands are not captured
  - after res_ready=1, start_ready returns 1 on the next cycle
- Assert rst_n=0 during the second RUN cycle of 0x1234+0x4321:
  - all outputs are at reset values
  - after release, 0x0001+0x0001 yields 0x0002 with no residue from the aborted operation
- With SUB_EN: 0x0005−0x0007 → 0xFFFE, cout_out=0; 0x0007−0x0005 → 0x0002, cout_out=1. Without SUB_EN: op=1, a=0x0005, b=0x0007, cin=0 → 0x000C.
- WIDTH=4: 0x9+0x8, cin=1 → sum_out=0x2, cout_out=1, res_valid after one RUN cycle.
